// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: IDLE/ACCESS/RESP FSM, one transaction per three cycles.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_BYTES = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          p1_err,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic          cmd_we;
    logic          cmd_port;
    logic          cmd_err;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [DW-1:0] rdata_q;
    logic          gnt0_q;
    logic          gnt1_q;
    logic          rv_q;
    logic          mwe_q;

    logic          win;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          sel_err;

`ifdef DMEM_ARB_RR_EN
    // last = port granted most recently; reset value 1 gives port 0 priority
    logic last;
    assign win = !p0_req ? 1'b1 : (p1_req ? ~last : 1'b0);
`else
    assign win = !p0_req;
`endif

    assign sel_we    = win ? p1_we    : p0_we;
    assign sel_addr  = win ? p1_addr  : p0_addr;
    assign sel_wdata = win ? p1_wdata : p0_wdata;
    assign sel_err   = (sel_addr[1:0] != 2'b00) ||
                       (sel_addr >= AW'(MEM_BYTES - 3));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cmd_we    <= 1'b0;
            cmd_port  <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata_q   <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rv_q      <= 1'b0;
            mwe_q     <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last      <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (p0_req || p1_req) begin
                        state     <= ACCESS;
                        cmd_we    <= sel_we;
                        cmd_port  <= win;
                        cmd_err   <= sel_err;
                        cmd_addr  <= sel_addr;
                        cmd_wdata <= sel_wdata;
                        gnt0_q    <= !win;
                        gnt1_q    <= win;
                        mwe_q     <= sel_we && !sel_err;
`ifdef DMEM_ARB_RR_EN
                        last      <= win;
`endif
                    end
                end
                ACCESS: begin
                    state   <= RESP;
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    mwe_q   <= 1'b0;
                    rv_q    <= 1'b1;
                    rdata_q <= (cmd_we || cmd_err) ? '0 : m_rdata;
                end
                RESP: begin
                    state <= IDLE;
                    rv_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign p0_gnt    = gnt0_q;
    assign p1_gnt    = gnt1_q;
    assign p0_rvalid = rv_q && !cmd_port;
    assign p1_rvalid = rv_q && cmd_port;
    assign p0_rdata  = p0_rvalid ? rdata_q : '0;
    assign p1_rdata  = p1_rvalid ? rdata_q : '0;
    assign p0_err    = p0_rvalid && cmd_err;
    assign p1_err    = p1_rvalid && cmd_err;
    assign m_we      = mwe_q;
    assign m_addr    = cmd_addr;
    assign m_wdata   = cmd_wdata;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random
// single-port traffic against a transaction-level memory model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic        m_we, busy;
    logic [31:0] m_addr, m_wdata, m_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mem     [64];
    logic [31:0] exp_mem [64];
    int          ref_last;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MEM_BYTES(256)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .busy(busy)
    );

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
        end else if (m_we && m_addr < 32'd256) begin
            mem[m_addr[7:2]] <= m_wdata;
        end
    end
    assign m_rdata = (m_addr < 32'd256) ? mem[m_addr[7:2]] : 32'd0;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 253);
    endfunction

    task automatic run_txn(input int p, input logic we,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output int gcyc, output int rcyc,
                           output logic [31:0] rd, output logic er,
                           output int nwe, output logic [31:0] wa,
                           output int other);
        logic g, rv, og, orv;
        @(negedge clk);
        if (p == 0) begin
            p0_req = 1; p0_we = we; p0_addr = addr; p0_wdata = wd;
        end else begin
            p1_req = 1; p1_we = we; p1_addr = addr; p1_wdata = wd;
        end
        gcyc = 0; rcyc = 0; rd = 0; er = 0; nwe = 0; wa = 0; other = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (m_we) begin
                nwe++;
                wa = m_addr;
            end
            g   = (p == 0) ? p0_gnt : p1_gnt;
            rv  = (p == 0) ? p0_rvalid : p1_rvalid;
            og  = (p == 0) ? p1_gnt : p0_gnt;
            orv = (p == 0) ? p1_rvalid : p0_rvalid;
            if (og || orv) other++;
            if (g && gcyc == 0) begin
                gcyc = c;
                p0_req = 0;
                p1_req = 0;
            end
            if (rv) begin
                rcyc = c;
                rd = (p == 0) ? p0_rdata : p1_rdata;
                er = (p == 0) ? p0_err : p1_err;
                break;
            end
        end
        p0_req = 0;
        p1_req = 0;
        ref_last = p;
    endtask

    task automatic test_reset;
        rst = 1; mem_clr = 1;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
        for (int i = 0; i < 64; i++) exp_mem[i] = 32'd0;
        ref_last = 1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err, p1_err,
             busy, m_we} !== 8'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=00000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_err,
                      p1_err, busy, m_we});
        end
        total++;
        if (m_addr !== 0 || m_wdata !== 0 || p0_rdata !== 0 ||
            p1_rdata !== 0) begin
            bad++;
            $display("FAIL reset_data addr=%h wdata=%h rd0=%h rd1=%h want 0",
                     m_addr, m_wdata, p0_rdata, p1_rdata);
        end
        @(negedge clk);
        rst = 0; mem_clr = 0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_write_read;
        int g, r, n, o;
        logic [31:0] rd, wa;
        logic er;
        run_txn(0, 1, 32'h10, 32'hDEADBEEF, g, r, rd, er, n, wa, o);
        exp_mem[4] = 32'hDEADBEEF;
        total++;
        if (g !== 1 || r !== 2) begin
            bad++;
            $display("FAIL wr_latency gnt=%0d rvalid=%0d want 1 2", g, r);
        end
        total++;
        if (n !== 1 || wa !== 32'h10 || er !== 0 || o !== 0) begin
            bad++;
            $display("FAIL wr_mem nwe=%0d addr=%h err=%b other=%0d want 1 10 0 0",
                     n, wa, er, o);
        end
        run_txn(1, 0, 32'h10, 32'h0, g, r, rd, er, n, wa, o);
        total++;
        if (r !== 2 || rd !== exp_mem[4] || er !== 0) begin
            bad++;
            $display("FAIL rd_p1 rvalid=%0d rdata=%h err=%b want 2 %h 0",
                     r, rd, er, exp_mem[4]);
        end
        total++;
        if (o !== 0 || n !== 0) begin
            bad++;
            $display("FAIL rd_p1_iso other=%0d nwe=%0d want 0 0", o, n);
        end
    endtask

    task automatic test_arbitration;
        int w [2];
        int ng, both, nrv, e0, e1;
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 0;
        p1_req = 1; p1_we = 0; p1_addr = 0;
        ng = 0; both = 0; nrv = 0;
        w[0] = -1; w[1] = -1;
`ifdef DMEM_ARB_RR_EN
        e0 = (ref_last == 0) ? 1 : 0;
        e1 = 1 - e0;
`else
        e0 = 0;
        e1 = 0;
`endif
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if ((p0_gnt && p1_gnt) || (p0_rvalid && p1_rvalid)) both++;
            if (p0_rvalid || p1_rvalid) nrv++;
            if (p0_gnt || p1_gnt) begin
                if (ng < 2) w[ng] = p1_gnt ? 1 : 0;
                ng++;
            end
        end
        p0_req = 0;
        p1_req = 0;
        ref_last = e1;
        total++;
        if (ng !== 2 || nrv !== 2) begin
            bad++;
            $display("FAIL arb_count grants=%0d rvalids=%0d want 2 2", ng, nrv);
        end
        total++;
        if (w[0] !== e0 || w[1] !== e1) begin
            bad++;
            $display("FAIL arb_order got=%0d,%0d want=%0d,%0d",
                     w[0], w[1], e0, e1);
        end
        total++;
        if (both !== 0) begin
            bad++;
            $display("FAIL arb_exclusive got=%0d want=0", both);
        end
    endtask

    task automatic test_errors;
        int g, r, n, o;
        logic [31:0] rd, wa;
        logic er;
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h11;
        bad_addr[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            run_txn(0, 1, bad_addr[k], 32'hA5A5A5A5, g, r, rd, er, n, wa, o);
            total++;
            if (r !== 2 || er !== 1 || rd !== 0 || n !== 0) begin
                bad++;
                $display("FAIL err_%h rvalid=%0d err=%b rdata=%h nwe=%0d want 2 1 0 0",
                         bad_addr[k], r, er, rd, n);
            end
        end
        run_txn(1, 0, 32'hFD, 32'h0, g, r, rd, er, n, wa, o);
        total++;
        if (er !== 1 || rd !== 0) begin
            bad++;
            $display("FAIL err_rd_fd err=%b rdata=%h want 1 0", er, rd);
        end
        run_txn(0, 1, 32'hFC, 32'h0BADF00D, g, r, rd, er, n, wa, o);
        exp_mem[63] = 32'h0BADF00D;
        total++;
        if (er !== 0 || n !== 1) begin
            bad++;
            $display("FAIL edge_fc err=%b nwe=%0d want 0 1", er, n);
        end
        run_txn(1, 0, 32'h10, 32'h0, g, r, rd, er, n, wa, o);
        total++;
        if (rd !== exp_mem[4] || er !== 0) begin
            bad++;
            $display("FAIL err_nowrite rdata=%h err=%b want %h 0",
                     rd, er, exp_mem[4]);
        end
    endtask

    task automatic test_reset_mid;
        int g, r, n, o, nrv;
        logic [31:0] rd, wa;
        logic er;
        run_txn(1, 1, 32'h20, 32'h11111111, g, r, rd, er, n, wa, o);
        exp_mem[8] = 32'h11111111;
        @(negedge clk);
        p1_req = 1; p1_we = 1; p1_addr = 32'h20; p1_wdata = 32'h22222222;
        @(posedge clk);
        #1;
        total++;
        if (m_we !== 1 || p1_gnt !== 1) begin
            bad++;
            $display("FAIL mid_access m_we=%b gnt=%b want 1 1", m_we, p1_gnt);
        end
        #1 rst = 1;
        #1;
        total++;
        if (m_we !== 0 || busy !== 0 || p1_gnt !== 0) begin
            bad++;
            $display("FAIL async_rst m_we=%b busy=%b gnt=%b want 0 0 0",
                     m_we, busy, p1_gnt);
        end
        p1_req = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        ref_last = 1;
        nrv = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (p1_rvalid || p0_rvalid) nrv++;
        end
        total++;
        if (nrv !== 0) begin
            bad++;
            $display("FAIL rst_no_rvalid got=%0d want=0", nrv);
        end
        run_txn(0, 0, 32'h20, 32'h0, g, r, rd, er, n, wa, o);
        total++;
        if (rd !== exp_mem[8]) begin
            bad++;
            $display("FAIL rst_no_write rdata=%h want=%h", rd, exp_mem[8]);
        end
    endtask

    task automatic test_random;
        int g, r, n, o, p, nw;
        logic [31:0] rd, wa, addr, wd, erd;
        logic er, we, eer;
        for (int i = 0; i < 40; i++) begin
            p  = $urandom_range(0, 1);
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = $urandom_range(0, 300);
            else addr = $urandom_range(0, 63) * 4;
            wd  = $urandom;
            eer = addr_bad(addr);
            erd = (we || eer) ? 32'd0 : exp_mem[addr / 4];
            nw  = (we && !eer) ? 1 : 0;
            run_txn(p, we, addr, wd, g, r, rd, er, n, wa, o);
            if (we && !eer) exp_mem[addr / 4] = wd;
            total++;
            if (g !== 1 || r !== 2 || o !== 0) begin
                bad++;
                $display("FAIL rnd%0d_timing gnt=%0d rvalid=%0d other=%0d want 1 2 0",
                         i, g, r, o);
            end
            total++;
            if (er !== eer || rd !== erd || n !== nw) begin
                bad++;
                $display("FAIL rnd%0d_data p%0d we=%b a=%h err=%b rd=%h nwe=%0d want %b %h %0d",
                         i, p, we, addr, er, rd, n, eer, erd, nw);
            end
        end
        total++;
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== exp_mem[i]) begin
                bad++;
                $display("FAIL mem_final word%0d got=%h want=%h",
                         i, mem[i], exp_mem[i]);
                break;
            end
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_arbitration;
        test_errors;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
